// File: rtl/telemetry_frame_sched.sv
// Periodic telemetry framer: on each period tick, walks the sensor register block
// and streams SYNC0, SYNC1, seq, payload bytes and a checksum over a valid/ready link.
module telemetry_frame_sched #(
    parameter logic [7:0] FIRST_ADDR = 8'd1,
    parameter logic [7:0] LAST_ADDR  = 8'd34,
    parameter int         PERIOD     = 100000,
    parameter logic [7:0] SYNC0      = 8'hA5,
    parameter logic [7:0] SYNC1      = 8'h5A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [7:0] reg_addr,
    input  logic [7:0] reg_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] frame_seq,
    output logic [7:0] overrun_cnt
);

    localparam int               CNT_W    = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        S_SYNC0,
        S_SYNC1,
        S_SEQ,
        FETCH,
        S_DATA,
        S_CSUM
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [7:0]       reg_addr_reg;
    logic [7:0]       sum_reg;
    logic [7:0]       tx_data_reg;
    logic             tx_valid_reg;
    logic             busy_reg;
    logic [7:0]       frame_seq_reg;
    logic [7:0]       overrun_reg;
    logic             tick;
    logic             handshake;

    assign tick      = enable && (count_reg == CNT_LAST);
    assign handshake = tx_valid_reg && tx_ready;

    assign reg_addr    = reg_addr_reg;
    assign tx_data     = tx_data_reg;
    assign tx_valid    = tx_valid_reg;
    assign busy        = busy_reg;
    assign frame_seq   = frame_seq_reg;
    assign overrun_cnt = overrun_reg;

    // Disabling holds the counter at zero so the next tick is a full period after re-enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (!enable || tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            reg_addr_reg  <= FIRST_ADDR;
            sum_reg       <= 8'h00;
            tx_data_reg   <= 8'h00;
            tx_valid_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            frame_seq_reg <= 8'h00;
            overrun_reg   <= 8'h00;
        end else begin
            // A tick landing on the final checksum handshake still counts as dropped.
            if (tick && (state_reg != IDLE) && (overrun_reg != 8'hFF)) begin
                overrun_reg <= overrun_reg + 8'd1;
            end

            case (state_reg)
                IDLE: begin
                    if (tick) begin
                        state_reg    <= S_SYNC0;
                        tx_data_reg  <= SYNC0;
                        tx_valid_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end
                S_SYNC0: begin
                    if (handshake) begin
                        state_reg   <= S_SYNC1;
                        tx_data_reg <= SYNC1;
                    end
                end
                S_SYNC1: begin
                    if (handshake) begin
                        state_reg   <= S_SEQ;
                        tx_data_reg <= frame_seq_reg;
                        sum_reg     <= frame_seq_reg;
                    end
                end
                S_SEQ: begin
                    if (handshake) begin
                        state_reg    <= FETCH;
                        tx_valid_reg <= 1'b0;
                        reg_addr_reg <= FIRST_ADDR;
                    end
                end
                // reg_addr has been stable for a full cycle, so reg_data is settled here.
                FETCH: begin
                    state_reg    <= S_DATA;
                    tx_data_reg  <= reg_data;
                    sum_reg      <= sum_reg + reg_data;
                    tx_valid_reg <= 1'b1;
                end
                S_DATA: begin
                    if (handshake) begin
                        if (reg_addr_reg == LAST_ADDR) begin
                            state_reg   <= S_CSUM;
                            tx_data_reg <= 8'h00 - sum_reg;
                        end else begin
                            state_reg    <= FETCH;
                            tx_valid_reg <= 1'b0;
                            reg_addr_reg <= reg_addr_reg + 8'd1;
                        end
                    end
                end
                S_CSUM: begin
                    if (handshake) begin
                        state_reg     <= IDLE;
                        tx_valid_reg  <= 1'b0;
                        busy_reg      <= 1'b0;
                        frame_seq_reg <= frame_seq_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    tx_valid_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

endmodule
